rps_game_ctrl: RTL
==================

Name: rps_game_ctrl

Overview:
- Rock-paper-scissors game controller; sits directly upstream of the VGA display stage.
- Drives that stage's state, com_hand, player_hand and result inputs.
- Takes one-cycle button pulses from the board debounce/one-pulse stage and picks the computer hand from a free-running LFSR.
- Sequences IDLE -> CHOOSE -> REVEAL -> RESULT using timed holds.

Parameters:
- REVEAL_CYCLES, 100000000: clk cycles spent in REVEAL before the result is shown (1 s at 100 MHz).
- RESULT_CYCLES, 300000000: clk cycles RESULT is held before auto-return to IDLE.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- clk  in  1  system clock (100 MHz board clock).
- rst  in  1  asynchronous, active-high reset.
- btn_start  in  1  one-cycle pulse: start or restart a round.
- btn_rock  in  1  one-cycle pulse: player picks rock.
- btn_paper  in  1  one-cycle pulse: player picks paper.
- btn_scissors  in  1  one-cycle pulse: player picks scissors.
- state  out  2  0=IDLE, 1=CHOOSE, 2=REVEAL, 3=RESULT.
- com_hand  out  2  0=none, 1=rock, 2=paper, 3=scissors.
- player_hand  out  2  same encoding as com_hand.
- result  out  2  0=none, 1=player win, 2=player lose, 3=draw.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst is asynchronous and active-high.
  - All outputs are registered with no combinational path from input to output.
- Reset values:
  - state=0, com_hand=0, player_hand=0, result=0.
  - Timer=0, LFSR=LFSR_SEED.
  - Reset mid-round aborts immediately to these values.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle in all states, never stalls.
  - Computer hand = (lfsr[7:0] mod 3) + 1, sampled on the capturing edge.
- IDLE:
  - btn_start -> CHOOSE on the next edge.
  - Hand buttons are ignored.
- CHOOSE:
  - Entry from any state clears com_hand, player_hand and result to 0.
  - Exactly one hand button high in a cycle: on that edge, player_hand takes that hand, com_hand takes the LFSR value, timer clears, and the state goes to REVEAL.
  - Two or more hand buttons in the same cycle: the cycle is ignored and the state stays CHOOSE.
  - btn_start is ignored. There is no timeout.
- REVEAL:
  - Timer increments each cycle. When timer == REVEAL_CYCLES-1, on that edge: result is computed, timer clears, and the state goes to RESULT.
  - Latency from hand press to result visible: REVEAL_CYCLES+1 edges.
  - All buttons are ignored, including btn_start.
- Result rule, evaluated on 2-bit hands p (player) and c (computer):
  - p==c -> 3 (draw).
  - ((p - c + 3) mod 3) == 1 -> 1 (win).
  - Otherwise -> 2 (lose).
  - Arithmetic uses at least 3 bits so the +3 does not wrap.
- RESULT:
  - Hands and result are held.
  - btn_start -> CHOOSE (new round, outputs cleared).
  - Timer == RESULT_CYCLES-1 -> IDLE, with com_hand, player_hand and result cleared to 0.
  - If btn_start and the timeout occur in the same cycle, btn_start wins and the state goes to CHOOSE.
- Timer:
  - Width is clog2 of max(REVEAL_CYCLES, RESULT_CYCLES).
  - Cleared on every state change. Never wraps while in a timed state.

Optional Feature:
- Macro: RPS_SCORE_EN.
- Defined:
  - Adds outputs win_cnt[7:0] and lose_cnt[7:0], reset to 0.
  - On the REVEAL->RESULT edge, win_cnt increments when result=1 and lose_cnt increments when result=2. Draws change neither.
  - Both counters saturate at 255.
  - Counters are not cleared by new rounds, only by rst.
- Undefined: no score ports or logic; the behaviour above is otherwise identical.

Test Plan (REVEAL_CYCLES=4, RESULT_CYCLES=8; bench carries an LFSR model):
- Reset values:
  - Stimulus: rst high, then released with no buttons pressed.
  - Response: state=0, hands=0, result=0; state stays 0 for 100 cycles.
- Full round, auto-return:
  - Stimulus: pulse btn_start, then btn_paper.
  - Response: state goes 1, then 2; player_hand=2; com_hand matches the model.
  - 4 cycles later: state=3, result matches the rule table (e.g. c=1 -> result=1).
  - 8 cycles after that: state=0 and all outputs 0.
- Result table exhaustive:
  - Stimulus: all 9 (p,c) pairs, forcing LFSR_SEED per run or selecting press timing from the model.
  - Response: draws on the diagonal; wins for (2,1), (3,2), (1,3); losses for the rest.
- Illegal multi-press and ignored inputs:
  - Stimulus: btn_rock and btn_scissors in the same cycle during CHOOSE.
  - Response: stays in CHOOSE with player_hand=0.
  - Stimulus: btn_start during REVEAL. Response: ignored.
- Restart collision and mid-round reset:
  - Stimulus: btn_start in the last RESULT cycle.
  - Response: state=1, outputs cleared.
  - Stimulus: rst asserted during REVEAL.
  - Response: immediate return to reset values without waiting for a clock edge.
- Score saturation (RPS_SCORE_EN):
  - Stimulus: 260 winning rounds.
  - Response: win_cnt=255, lose_cnt=0.
  - Stimulus: one further losing round. Response: lose_cnt=1.

Source files
------------

// File: rtl/rps_game_ctrl.sv
// rps_game_ctrl -- rock-paper-scissors round sequencer feeding the VGA stage.
//
// Sequences IDLE -> CHOOSE -> REVEAL -> RESULT with timed holds. The computer
// hand comes from a free-running 16-bit Fibonacci LFSR (taps 16,14,13,11),
// sampled on the edge that captures the player's hand.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_start    one-cycle pulse: start / restart a round
//   btn_rock     one-cycle pulse: player picks rock
//   btn_paper    one-cycle pulse: player picks paper
//   btn_scissors one-cycle pulse: player picks scissors
//   state        0=IDLE 1=CHOOSE 2=REVEAL 3=RESULT
//   com_hand     0=none 1=rock 2=paper 3=scissors
//   player_hand  same encoding as com_hand
//   result       0=none 1=player win 2=player lose 3=draw
//   win_cnt      saturating win counter   (only with RPS_SCORE_EN)
//   lose_cnt     saturating loss counter  (only with RPS_SCORE_EN)
//
// Optional feature macro: RPS_SCORE_EN adds the win/lose score counters.
module rps_game_ctrl #(
    parameter int unsigned REVEAL_CYCLES = 100000000,
    parameter int unsigned RESULT_CYCLES = 300000000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_rock,
    input  logic       btn_paper,
    input  logic       btn_scissors,
    output logic [1:0] state,
    output logic [1:0] com_hand,
    output logic [1:0] player_hand,
`ifdef RPS_SCORE_EN
    output logic [7:0] win_cnt,
    output logic [7:0] lose_cnt,
`endif
    output logic [1:0] result
);

    localparam int unsigned MAX_CYCLES = (REVEAL_CYCLES > RESULT_CYCLES) ? REVEAL_CYCLES : RESULT_CYCLES;
    localparam int unsigned TIMER_W    = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] REVEAL_LAST = TIMER_W'(REVEAL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHOOSE = 2'd1,
        S_REVEAL = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t             st;
    logic [TIMER_W-1:0] timer;
    logic [15:0]        lfsr;
    logic               lfsr_fb;
    logic [1:0]         lfsr_hand;
    logic               hand_valid;
    logic [1:0]         hand_sel;
    logic [2:0]         hand_diff;
    logic [1:0]         round_result;

    assign state = st;

    always_comb begin
        lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        lfsr_hand = 2'(lfsr[7:0] % 8'd3) + 2'd1;
    end

    // Exactly one hand button accepted; any multi-press is dropped.
    always_comb begin
        hand_valid = 1'b1;
        hand_sel   = 2'd0;
        case ({btn_rock, btn_paper, btn_scissors})
            3'b100:  hand_sel = 2'd1;
            3'b010:  hand_sel = 2'd2;
            3'b001:  hand_sel = 2'd3;
            default: hand_valid = 1'b0;
        endcase
    end

    // 3-bit arithmetic so the +3 bias never wraps before the mod.
    always_comb begin
        hand_diff    = {1'b0, player_hand} - {1'b0, com_hand} + 3'd3;
        round_result = 2'd2;
        if (player_hand == com_hand)
            round_result = 2'd3;
        else if ((hand_diff % 3'd3) == 3'd1)
            round_result = 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            timer       <= '0;
            lfsr        <= LFSR_SEED;
            com_hand    <= '0;
            player_hand <= '0;
            result      <= '0;
`ifdef RPS_SCORE_EN
            win_cnt     <= '0;
            lose_cnt    <= '0;
`endif
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            case (st)
                S_IDLE: begin
                    if (btn_start) begin
                        st          <= S_CHOOSE;
                        timer       <= '0;
                        com_hand    <= '0;
                        player_hand <= '0;
                        result      <= '0;
                    end
                end
                S_CHOOSE: begin
                    if (hand_valid) begin
                        st          <= S_REVEAL;
                        timer       <= '0;
                        player_hand <= hand_sel;
                        com_hand    <= lfsr_hand;
                    end
                end
                S_REVEAL: begin
                    if (timer == REVEAL_LAST) begin
                        st     <= S_RESULT;
                        timer  <= '0;
                        result <= round_result;
`ifdef RPS_SCORE_EN
                        if (round_result == 2'd1 && win_cnt != 8'hFF)
                            win_cnt <= win_cnt + 8'd1;
                        if (round_result == 2'd2 && lose_cnt != 8'hFF)
                            lose_cnt <= lose_cnt + 8'd1;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESULT: begin
                    // Restart takes priority over the auto-return timeout.
                    if (btn_start) begin
                        st          <= S_CHOOSE;
                        timer       <= '0;
                        com_hand    <= '0;
                        player_hand <= '0;
                        result      <= '0;
                    end else if (timer == RESULT_LAST) begin
                        st          <= S_IDLE;
                        timer       <= '0;
                        com_hand    <= '0;
                        player_hand <= '0;
                        result      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
